riscv_data_mem_responder: RTL
=============================

// Module: riscv_data_mem_responder
// PURPOSE
//   Memory-side responder for the RiscV_SingleCycle load/store port, decoupled from the core by a
//   valid/ready request channel and a valid/ready response channel.
//   Holds DEPTH x 32-bit words and inserts LATENCY wait states per access, so the core and its
//   benches see realistic multi-cycle data memory.
//   Reports misaligned or out-of-range accesses as errors and never corrupts memory on them.
// PARAMETERS
//   DEPTH    256  number of 32-bit words; power of two, >= 4
//   LATENCY  2    wait cycles between acceptance and response, 0..15
// PORTS
//   clk         in   1   single clock, rising edge
//   reset_n     in   1   asynchronous, active-low reset
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept a request
//   req_we      in   1   1 = store, 0 = load
//   req_addr    in   32  byte address (the core's alu_result)
//   req_wdata   in   32  store data (the core's write_data)
//   req_wstrb   in   4   byte-lane enables; bit i enables wdata[8i+7:8i]
//   resp_valid  out  1   response present
//   resp_ready  in   1   core accepts response
//   resp_rdata  out  32  load data (the core's read_data); 0 for stores and errors
//   resp_err    out  1   misaligned or out-of-range access
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   - reset_n low: state = IDLE, wait counter = 0, req_ready = 0 while reset_n is low, resp_valid = 0,
//     resp_rdata = 0, resp_err = 0. Memory array is not cleared.
//   - FSM states: IDLE, WAIT, RESP.
//   - IDLE: req_ready = 1. On req_valid && req_ready:
//     - register we/addr/wdata/wstrb;
//     - go to WAIT with counter = LATENCY if LATENCY > 0, otherwise go directly to RESP.
//   - WAIT: req_ready = 0. Counter decrements each cycle. Leave for RESP on the cycle the counter
//     reaches 1 in WAIT.
//   - Timing: resp_valid rises exactly LATENCY+1 cycles after the acceptance edge.
//   - Commit: the access is performed on the edge that enters RESP.
//     - Store: each byte lane with wstrb[i] = 1 is written. wstrb = 0000 gives a valid no-op response.
//     - Load: resp_rdata = mem[addr[log2(DEPTH)+1:2]], the full word regardless of wstrb.
//   - Error when addr[1:0] != 0 or addr >= DEPTH*4:
//     - no write occurs;
//     - resp_rdata = 0 and resp_err = 1;
//     - latency is unchanged.
//   - RESP:
//     - resp_valid = 1; resp_rdata and resp_err are held stable until resp_valid && resp_ready.
//     - On the handshake: go to IDLE and clear resp_valid, resp_rdata and resp_err on the same edge.
//   - Throughput: req_ready = 0 in WAIT and RESP, so there is at most one outstanding request.
//     The next request is accepted no earlier than the cycle after the response handshake.
//   - Request signals are ignored outside IDLE and may change freely there.
//   - Reset mid-operation drops the pending access. A store that has not yet reached RESP never
//     writes. A store already committed stays in memory.
//   - Read-after-write: a load issued after a store handshake returns the stored data.
// TESTING
//   1. LATENCY=2: store 0xDEADBEEF @0x10, wstrb=1111 -> resp_valid 3 cycles after accept, err=0,
//      rdata=0; then load @0x10 -> rdata=0xDEADBEEF.
//   2. Store 0x0000AA00 @0x10, wstrb=0010 -> load @0x10 returns 0xDEADAAEF.
//   3. Load @0x12 -> err=1, rdata=0; store @0x12 -> err=1, and a load of word @0x10 is unchanged.
//   4. Store 0x12345678 @DEPTH*4 -> err=1; a subsequent load @0x0 and load @(DEPTH-1)*4 are unchanged.
//   5. Backpressure: hold resp_ready=0 for 5 cycles during a load response -> resp_valid, rdata and
//      err stay constant and req_ready stays 0 throughout; handshake -> req_ready=1 on the next cycle.
//   6. Pull reset_n low during WAIT of a store 0xCAFEF00D @0x20 -> all outputs 0 immediately; after
//      release, load @0x20 returns the old value. Also cover LATENCY=0: response exactly 1 cycle
//      after accept.

Source files
------------

// File: rtl/riscv_data_mem_responder.sv
// Data-memory responder for the single-cycle RISC-V load/store port.
// Requests and responses use valid/ready handshakes, with LATENCY wait states between them.
module riscv_data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        err_q, err_d;
    logic        rd_ok_q, rd_ok_d;
    logic [31:0] mem_rd_q;
    logic [31:0] mem [DEPTH];

    logic          load_req, commit, live;
    logic          acc_we, acc_err;
    logic [31:0]   acc_addr, acc_wdata;
    logic [3:0]    acc_wstrb, lane_we;
    logic [AW-1:0] acc_idx;

    // With zero latency the access commits on the acceptance edge, so it uses the live request.
    assign live      = (state_q == IDLE);
    assign acc_we    = live ? req_we    : we_q;
    assign acc_addr  = live ? req_addr  : addr_q;
    assign acc_wdata = live ? req_wdata : wdata_q;
    assign acc_wstrb = live ? req_wstrb : wstrb_q;
    assign acc_idx   = acc_addr[AW+1:2];
    assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = commit && acc_we && !acc_err && acc_wstrb[gi];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_req = 1'b0;
        commit   = 1'b0;
        err_d    = err_q;
        rd_ok_d  = rd_ok_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    load_req = 1'b1;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                    rd_ok_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d   = acc_err;
            rd_ok_d = !acc_err && !acc_we;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_ok_q <= rd_ok_d;
            if (load_req) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
        end
    end

    // Storage has no reset so it maps onto block RAM; the read port is registered at commit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
        if (commit) begin
            mem_rd_q <= mem[acc_idx];
        end
    end

    assign req_ready  = reset_n && (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rd_ok_q ? mem_rd_q : 32'd0;
    assign resp_err   = err_q;
endmodule
